// File: rtl/rv32i_types.sv
// Shared core types: the CDB broadcast packet used by the arbiter, ROB and
// reservation stations, plus the number of CDB requesters.
package rv32i_types;

    localparam int CDB_N_REQ     = 4;
    localparam int CDB_TAG_W     = 4;
    localparam int CDB_ROB_DEPTH = 16;
    localparam int CDB_ROB_PTR_W = $clog2(CDB_ROB_DEPTH);

    typedef struct packed {
        logic [CDB_TAG_W-1:0]     tag;
        logic [31:0]              wdata;
        logic [CDB_ROB_PTR_W-1:0] inst_id;
    } cdb_pkt_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Result request bundle from the execution units and the CDB broadcast.
// master = execution-unit side, slave = arbiter side.
interface cdb_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int TAG_W     = 4,
    parameter int ROB_PTR_W = 4
);
    logic [N_REQ-1:0]           req;
    logic [N_REQ*TAG_W-1:0]     req_tag;
    logic [N_REQ*32-1:0]        req_wdata;
    logic [N_REQ*ROB_PTR_W-1:0] req_inst_id;
    logic [N_REQ-1:0]           rdy;
    logic                       cdb_vld;
    logic [TAG_W-1:0]           cdb_tag;
    logic [31:0]                cdb_wdata;
    logic [ROB_PTR_W-1:0]       cdb_inst_id;

    modport master (
        output req, req_tag, req_wdata, req_inst_id,
        input  rdy, cdb_vld, cdb_tag, cdb_wdata, cdb_inst_id
    );

    modport slave (
        input  req, req_tag, req_wdata, req_inst_id,
        output rdy, cdb_vld, cdb_tag, cdb_wdata, cdb_inst_id
    );
endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first requesting index at or above prio, wrapping.
// Returns a one-hot grant, the winner index and whether anything won.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] prio,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          found
);

    int pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(prio) + i) % N;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one execution unit per cycle and registers it onto the
// broadcast. Define CDB_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int N_REQ     = CDB_N_REQ,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int ROB_DEPTH = CDB_ROB_DEPTH,
    parameter int ROB_PTR_W = $clog2(ROB_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    cdb_arbiter_if.slave  bus,
    output logic [31:0]   conflict_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]     pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_found;
    logic                 grant_en;
    logic                 grant;
    logic [TAG_W-1:0]     win_tag;
    logic [31:0]          win_wdata;
    logic [ROB_PTR_W-1:0] win_inst_id;

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        pick_gnt   = '0;
        pick_idx   = '0;
        pick_found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!pick_found && bus.req[i]) begin
                pick_found  = 1'b1;
                pick_gnt[i] = 1'b1;
                pick_idx    = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] prio;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (bus.req),
        .prio  (prio),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // prio moves just past the winner; flush and reset both suppress grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= '0;
        end else if (grant) begin
            if (pick_idx == PW'(N_REQ - 1))
                prio <= '0;
            else
                prio <= pick_idx + PW'(1);
        end
    end
`endif

    assign grant_en = rst_n & ~flush;
    assign grant    = grant_en & pick_found;
    assign bus.rdy  = grant_en ? pick_gnt : '0;

    always_comb begin
        win_tag     = '0;
        win_wdata   = '0;
        win_inst_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                win_tag     = bus.req_tag[i*TAG_W +: TAG_W];
                win_wdata   = bus.req_wdata[i*32 +: 32];
                win_inst_id = bus.req_inst_id[i*ROB_PTR_W +: ROB_PTR_W];
            end
        end
    end

    // Payload holds its last value when idle so consumers see stable fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.cdb_vld     <= 1'b0;
            bus.cdb_tag     <= '0;
            bus.cdb_wdata   <= '0;
            bus.cdb_inst_id <= '0;
        end else if (grant) begin
            bus.cdb_vld     <= 1'b1;
            bus.cdb_tag     <= win_tag;
            bus.cdb_wdata   <= win_wdata;
            bus.cdb_inst_id <= win_inst_id;
        end else begin
            bus.cdb_vld     <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            conflict_cnt <= '0;
        else if (!flush && ($countones(bus.req) > 1))
            conflict_cnt <= conflict_cnt + 32'd1;
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reference model plus a scoreboard of
// expected CDB broadcasts. Build with CDB_ARB_FIXED_PRIO_EN for the fixed-priority variant.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] conflict_cnt;

    cdb_arbiter_if #(.N_REQ(4), .TAG_W(4), .ROB_PTR_W(4)) bus ();

    cdb_arbiter #(.N_REQ(4), .TAG_W(4), .ROB_DEPTH(16), .ROB_PTR_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic     vld;
        cdb_pkt_t pkt;
    } exp_t;

    int          checks   = 0;
    int          failures = 0;
    logic [3:0]  tags [4];
    logic [31:0] datas[4];
    logic [3:0]  ids  [4];
    int          m_prio;
    logic [31:0] m_cnt;
    cdb_pkt_t    m_last;
    exp_t        sb[$];
    exp_t        exp_entry;
    logic [3:0]  obs_rdy, exp_rdy;
    logic        obs_vld;
    cdb_pkt_t    obs_pkt;
    logic [31:0] obs_cnt;

    // Drives one cycle: predicts grant and next broadcast, clocks, samples outputs
    task automatic advance();
        int w;
        int idx;
        for (int i = 0; i < 4; i++) begin
            bus.req_tag[i*4 +: 4]      = tags[i];
            bus.req_wdata[i*32 +: 32]  = datas[i];
            bus.req_inst_id[i*4 +: 4]  = ids[i];
        end
        #1;
        obs_rdy = bus.rdy;
        exp_rdy = '0;
        w = -1;
        if (rst_n && !flush) begin
            for (int k = 0; k < 4; k++) begin
`ifdef CDB_ARB_FIXED_PRIO_EN
                idx = k;
`else
                idx = (m_prio + k) % 4;
`endif
                if (w < 0 && bus.req[idx]) w = idx;
            end
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
        if (!rst_n) begin
            m_last = '0;
            m_prio = 0;
            m_cnt  = '0;
            sb.push_back({1'b0, m_last});
        end else begin
            if (w >= 0) begin
                m_last = {tags[w], datas[w], ids[w]};
                m_prio = (w + 1) % 4;
                sb.push_back({1'b1, m_last});
            end else begin
                sb.push_back({1'b0, m_last});
            end
            if (!flush && $countones(bus.req) >= 2) m_cnt = m_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
        obs_vld   = bus.cdb_vld;
        obs_pkt   = {bus.cdb_tag, bus.cdb_wdata, bus.cdb_inst_id};
        obs_cnt   = conflict_cnt;
        exp_entry = sb.pop_front();
        @(negedge clk);
    endtask

    task automatic set_unit(input int i, input logic [3:0] t, input logic [31:0] d, input logic [3:0] id);
        tags[i]  = t;
        datas[i] = d;
        ids[i]   = id;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req = 4'b1111;
        for (int c = 0; c < 2; c++) begin
            advance();
            checks++; if (obs_rdy !== 4'b0000) begin failures++; $display("[TB] FAIL reset_rdy: got %b expected 0000", obs_rdy); end
            checks++; if (obs_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_vld: got %b expected 0", obs_vld); end
            checks++; if (obs_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_cnt: got %0d expected 0", obs_cnt); end
            checks++; if (obs_pkt !== '0) begin failures++; $display("[TB] FAIL reset_pkt: got %h expected 0", obs_pkt); end
        end
        rst_n = 1'b1;
        advance();
        checks++; if (obs_rdy !== 4'b0001) begin failures++; $display("[TB] FAIL release_rdy: got %b expected 0001", obs_rdy); end
        checks++; if (obs_vld !== 1'b1) begin failures++; $display("[TB] FAIL release_vld: got %b expected 1", obs_vld); end
        bus.req = 4'b0000;
        advance();
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        rst_n = 1'b0;
        bus.req = 4'b1111;
        advance();
        advance();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            advance();
            want = 4'b0001 << (c % 4);
            checks++; if (obs_rdy !== want) begin failures++; $display("[TB] FAIL rr_order c=%0d: got %b expected %b", c, obs_rdy, want); end
            checks++; if (obs_vld !== 1'b1 || obs_pkt !== {tags[c%4], datas[c%4], ids[c%4]}) begin
                failures++; $display("[TB] FAIL rr_bcast c=%0d: got vld=%b pkt=%h expected vld=1 pkt=%h", c, obs_vld, obs_pkt, {tags[c%4], datas[c%4], ids[c%4]});
            end
        end
        checks++; if (obs_cnt !== 32'd8) begin failures++; $display("[TB] FAIL rr_cnt: got %0d expected 8", obs_cnt); end
        bus.req = 4'b0000;
    endtask

    task automatic test_single();
        set_unit(2, 4'd5, 32'h1234, 4'd3);
        bus.req = 4'b0100;
        advance();
        checks++; if (obs_rdy !== 4'b0100) begin failures++; $display("[TB] FAIL single_rdy: got %b expected 0100", obs_rdy); end
        checks++; if (obs_vld !== 1'b1) begin failures++; $display("[TB] FAIL single_vld: got %b expected 1", obs_vld); end
        checks++; if (obs_pkt !== {4'd5, 32'h1234, 4'd3}) begin failures++; $display("[TB] FAIL single_pkt: got %h expected %h", obs_pkt, {4'd5, 32'h1234, 4'd3}); end
        bus.req = 4'b0000;
        advance();
        checks++; if (obs_rdy !== 4'b0000) begin failures++; $display("[TB] FAIL idle_rdy: got %b expected 0000", obs_rdy); end
        checks++; if (obs_vld !== 1'b0) begin failures++; $display("[TB] FAIL idle_vld: got %b expected 0", obs_vld); end
        checks++; if (obs_pkt !== {4'd5, 32'h1234, 4'd3}) begin failures++; $display("[TB] FAIL idle_hold: got %h expected %h", obs_pkt, {4'd5, 32'h1234, 4'd3}); end
    endtask

    task automatic test_prio_wrap();
        bus.req = 4'b0011;
        advance();
        checks++; if (obs_rdy !== 4'b0001) begin failures++; $display("[TB] FAIL wrap_first: got %b expected 0001", obs_rdy); end
        advance();
        checks++; if (obs_rdy !== 4'b0010) begin failures++; $display("[TB] FAIL wrap_second: got %b expected 0010", obs_rdy); end
        checks++; if (obs_cnt !== m_cnt) begin failures++; $display("[TB] FAIL wrap_cnt: got %0d expected %0d", obs_cnt, m_cnt); end
        bus.req = 4'b0000;
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before;
        cnt_before = m_cnt;
        flush = 1'b1;
        bus.req = 4'b1010;
        advance();
        checks++; if (obs_rdy !== 4'b0000) begin failures++; $display("[TB] FAIL flush_rdy: got %b expected 0000", obs_rdy); end
        checks++; if (obs_vld !== 1'b0) begin failures++; $display("[TB] FAIL flush_vld: got %b expected 0", obs_vld); end
        checks++; if (obs_cnt !== cnt_before) begin failures++; $display("[TB] FAIL flush_cnt: got %0d expected %0d", obs_cnt, cnt_before); end
        flush = 1'b0;
        advance();
        checks++; if (obs_rdy !== 4'b1000) begin failures++; $display("[TB] FAIL flush_prio_hold: got %b expected 1000", obs_rdy); end
        checks++; if (obs_vld !== 1'b1) begin failures++; $display("[TB] FAIL after_flush_vld: got %b expected 1", obs_vld); end
        bus.req = 4'b0000;
    endtask

    task automatic test_fixed();
        bus.req = 4'b0011;
        for (int c = 0; c < 3; c++) begin
            advance();
            checks++; if (obs_rdy !== 4'b0001) begin failures++; $display("[TB] FAIL fixed_rdy c=%0d: got %b expected 0001", c, obs_rdy); end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_reset_mid();
        set_unit(0, 4'd9, 32'hDEAD_BEEF, 4'd7);
        bus.req = 4'b0001;
        rst_n = 1'b0;
        advance();
        checks++; if (obs_rdy !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_rdy: got %b expected 0000", obs_rdy); end
        checks++; if (obs_vld !== 1'b0 || obs_pkt !== '0) begin failures++; $display("[TB] FAIL midrst_bcast: got vld=%b pkt=%h expected vld=0 pkt=0", obs_vld, obs_pkt); end
        rst_n = 1'b1;
        bus.req = 4'b0000;
        advance();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 4; i++) set_unit(i, 4'($urandom), $urandom, 4'($urandom));
            bus.req = 4'($urandom);
            flush = ($urandom_range(0, 7) == 0);
            advance();
            checks++; if (obs_rdy !== exp_rdy) begin failures++; $display("[TB] FAIL b2b_rdy c=%0d: got %b expected %b", c, obs_rdy, exp_rdy); end
            checks++; if (obs_vld !== exp_entry.vld || obs_pkt !== exp_entry.pkt) begin
                failures++; $display("[TB] FAIL b2b_bcast c=%0d: got vld=%b pkt=%h expected vld=%b pkt=%h", c, obs_vld, obs_pkt, exp_entry.vld, exp_entry.pkt);
            end
            checks++; if (obs_cnt !== m_cnt) begin failures++; $display("[TB] FAIL b2b_cnt c=%0d: got %0d expected %0d", c, obs_cnt, m_cnt); end
        end
        flush = 1'b0;
        bus.req = 4'b0000;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        bus.req = '0;
        m_prio = 0;
        m_cnt  = '0;
        m_last = '0;
        for (int i = 0; i < 4; i++) set_unit(i, 4'(i + 1), 32'hA000_0000 + 32'(i), 4'(8 + i));
        @(negedge clk);
        $display("[TB] starting cdb_arbiter bench");
        test_reset();
`ifdef CDB_ARB_FIXED_PRIO_EN
        test_single();
        test_fixed();
`else
        test_round_robin();
        test_single();
        test_prio_wrap();
        test_flush();
`endif
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) among the execution units (ALU, MUL/DIV, JMP, LSU) of the out-of-order core. Each unit presents a held result request; the arbiter grants at most one per cycle and registers the winner onto the CDB broadcast to the reservation stations, register file and ROB. It also squashes requests and the broadcast on a branch/jump flush.

## Interface
- `N_REQ`, default 4: number of requesting execution units; index 0 is the ALU.
- `TAG_W`, default 4: physical-register tag width.
- `ROB_DEPTH`, default 16: ROB entries.
- `ROB_PTR_W`, default `$clog2(ROB_DEPTH)`: inst_id width.
- `clk`, in, 1: clock. One clock domain.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `flush`, in, 1: pipeline flush from the jump unit.
- `req`, in, N_REQ: per-unit result-valid; the unit holds it until granted.
- `req_tag`, in, N_REQ*TAG_W: per-unit destination tag; slice i belongs to unit i.
- `req_wdata`, in, N_REQ*32: per-unit result data.
- `req_inst_id`, in, N_REQ*ROB_PTR_W: per-unit ROB id.
- `rdy`, out, N_REQ: one-hot grant for this cycle, combinational.
- `cdb_vld`, out, 1: broadcast valid.
- `cdb_tag`, out, TAG_W: broadcast tag.
- `cdb_wdata`, out, 32: broadcast data.
- `cdb_inst_id`, out, ROB_PTR_W: broadcast ROB id.
- `conflict_cnt`, out, 32: count of cycles with two or more requests active.

## Operation
- A transfer happens for unit i when `req[i] && rdy[i]`. At most one `rdy` bit is high, and only for a requesting unit.
- Default arbitration is round-robin.
  - Pointer `prio`, width $clog2(N_REQ), reset 0.
  - The winner is the first requesting index at or above `prio`, wrapping modulo N_REQ.
  - After any grant, `prio` becomes winner+1. It wraps from N_REQ-1 to 0.
  - With no grant, `prio` holds.
- When `flush` is high:
  - `rdy` is all zeros.
  - `prio` holds.
  - The next-cycle `cdb_vld` is 0.
  - Units are responsible for dropping their own `req` on flush.
- Output register:
  - On a grant, load `cdb_vld`=1 and the winner's tag, wdata and inst_id.
  - With no grant, `cdb_vld`=0; tag, wdata and inst_id hold their last values.
- There is no CDB backpressure. Every consumer accepts the broadcast in the cycle it is valid.
- `conflict_cnt` increments by 1 in every non-flush cycle with popcount(req) ≥ 2. It wraps at 2^32. It is saturation-free.
- Reset (`rst_n`=0 at a clock edge) sets all of these to 0:
  - `cdb_vld`, `cdb_tag`, `cdb_wdata`, `cdb_inst_id`
  - `prio`, `conflict_cnt`
- Reset mid-transfer discards the pending broadcast.
- While in reset, `rdy` is all zeros.

## Timing
- Grant latency is 0 cycles: `rdy` is a combinational function of `req`, `prio` and `flush`.
- Broadcast latency is 1 cycle: a result granted in cycle t appears on the CDB in cycle t+1 for exactly one cycle.
- Back-to-back grants are allowed, one per cycle. Sustained throughput is one result per cycle.
- A unit that registers its `req`, drops it on `req && rdy`, and re-raises it in the same cycle a new result is written is legal. It is re-arbitrated in the next cycle.
- `flush` and a request in the same cycle: no grant, and nothing is broadcast at t+1.
- Fairness: a continuously requesting unit is granted within N_REQ cycles of raising `req`, except during flush cycles.

## Configuration
- Macro `CDB_ARB_FIXED_PRIO_EN`.
- When defined:
  - Fixed priority: the lowest requesting index wins.
  - `prio` is not implemented.
  - The starvation bound no longer applies.
- When undefined: round-robin as described under Operation.
- All other behaviour is identical in both cases.

## Structure
- Shared package `rv32i_types` holds:
  - the `cdb_pkt_t` struct (tag, wdata, inst_id), which is reused by the ROB and reservation stations;
  - the `CDB_N_REQ` constant.
- Sub-module `rr_pick`, parameterised on N, takes `req` and `prio` and returns a one-hot grant plus the winner index. It is instantiated once.
- Under the macro, `rr_pick` is bypassed with a fixed-priority pick.
- Output register and counter live in the top.

## Test plan
- Reset with `rst_n`=0 for 2 cycles and `req`=4'b1111 → `rdy`=0, `cdb_vld`=0, `conflict_cnt`=0. At the first edge after release, unit 0 is granted.
- Single request: `req`=4'b0100, unit 2 tag=5, wdata=0x1234, inst_id=3 → `rdy`=4'b0100 in the same cycle. Next cycle: `cdb_vld`=1, tag 5, data 0x1234, id 3. The cycle after: `cdb_vld`=0.
- All four requesting and held for 8 cycles from reset → grants in order 0,1,2,3,0,1,2,3. `conflict_cnt`=8.
- `prio`=3 and `req`=4'b0011 → unit 0 is granted, then `prio`=1, then unit 1 is granted.
- `flush`=1 with `req`=4'b1010 → `rdy`=0, next-cycle `cdb_vld`=0, `prio` unchanged, `conflict_cnt` unchanged.
- With `CDB_ARB_FIXED_PRIO_EN`, `req`=4'b0011 held for 3 cycles → unit 0 is granted all 3 cycles and unit 1 never.
